pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives hold and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects three conditions: load-use hazards, EX-stage control redirects, and multi-cycle data-memory waits. A small FSM tracks the memory wait and enforces a timeout.

Parameters:
REG_ADDR_W, 5, register-file address width.
MEM_TIMEOUT, 16, number of consecutive not-ready cycles before a memory access is abandoned; 0 disables the timeout.
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  pipeline clock, rising edge.
resetn  in  1  asynchronous active-low reset.
id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
ex_is_load  in  1  EX instruction writeback select is LOAD.
ex_redirect  in  1  taken branch or jump resolved in EX.
mem_req  in  1  MEM stage holds a valid load or store.
mem_ready  in  1  data memory completes the access this cycle.
stall_if  out  1  hold PC and IF/ID.
stall_id  out  1  hold ID/EX input selection (ID instruction re-presented).
stall_ex  out  1  hold ID/EX and EX/MEM.
stall_mem  out  1  hold EX/MEM.
flush_id  out  1  clear IF/ID to NOP.
bubble_ex  out  1  load NOP into ID/EX.
bubble_wb  out  1  load NOP into MEM/WB (write enable 0, sel 2'b00, data 0).
mem_timeout  out  1  one-cycle pulse when an access is abandoned.
err_sticky  out  1  set on any timeout; cleared only by reset.
perf_lu, perf_flush, perf_memwait  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Reset: asynchronous. State goes to RUN, wait counter to 0, err_sticky to 0, perf counters to 0. All outputs are gated to 0 while resetn=0, including mid-wait.
- The control outputs are combinational from state, counter and inputs. They take effect on the same edge at which the pipeline registers sample.
- Load-use: lu = ex_is_load && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). It produces exactly one bubble: stall_if=1, stall_id=1, bubble_ex=1.
- Redirect: ex_redirect=1 gives flush_id=1 and bubble_ex=1, with stall_if=0. Redirect beats load-use in the same cycle, because the ID instruction is wrong-path.
- Memory wait has the highest priority. The condition is (state==RUN && mem_req && !mem_ready) or state==MEM_WAIT && !mem_ready && not timed out. It asserts stall_if, stall_id, stall_ex, stall_mem and bubble_wb. Load-use and redirect are suppressed, because EX is frozen and they are re-evaluated after release.
- FSM RUN:
  - Goes to MEM_WAIT when mem_req && !mem_ready; the counter loads 1.
  - A zero-latency access (mem_req && mem_ready) stays in RUN with no stall.
- FSM MEM_WAIT, when mem_ready=1:
  - Stalls are released that cycle.
  - State returns to RUN and the counter clears.
- FSM MEM_WAIT, when mem_ready=0:
  - If MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1, that cycle releases the stalls and keeps bubble_wb=1 (the load result is dropped).
  - That cycle also pulses mem_timeout, sets err_sticky and returns to RUN.
  - Otherwise the counter increments.
- Counter width is $clog2(MEM_TIMEOUT+1), minimum 1. It never wraps, because the timeout fires first.
- mem_ready while in RUN without mem_req is ignored.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: three saturating CNT_W counters.
  - perf_lu increments on each load-use bubble.
  - perf_flush increments on each redirect flush.
  - perf_memwait increments on each memory-stall cycle.
  - Each counter holds at all-ones.
- Undefined: the counter logic is not built and the perf ports are tied to 0. The ports always exist.

Decomposition:
- Package hazard_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - the writeback select encodings (ALU=2'b00, LOAD=2'b01, PC4=2'b10);
  - the default REG_ADDR_W.
- One sub-module, hazard_sat_counter (parameter W; inputs clk, resetn, inc; output count), is instantiated three times under the macro.

Test Plan:
- ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of stall_if/stall_id/bubble_ex=1. Same with ex_rd=0 -> no stall.
- Load-use and ex_redirect=1 in the same cycle -> flush_id=1, bubble_ex=1, stall_if=0.
- mem_req=1 with mem_ready low for 3 cycles then high -> stall_mem=1 for exactly 3 cycles. With the macro defined, perf_memwait=3.
- MEM_TIMEOUT=4, mem_ready held 0 -> stalls for 3 cycles. In the 4th cycle mem_timeout pulses, bubble_wb=1, stalls drop, err_sticky=1 until reset.
- resetn driven low in the 2nd MEM_WAIT cycle -> all outputs 0 immediately. After release, state is RUN and counter is 0.
- mem_ready held 1 with mem_req toggling -> no stall is ever asserted.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer:
// FSM state, writeback-select encodings and the memory-wait counter sizing.
package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef enum logic [1:0] {
    ALU  = 2'b00,
    LOAD = 2'b01,
    PC4  = 2'b10
  } wb_sel_e;

  // Wait counter must hold MEM_TIMEOUT itself; a disabled timeout still needs one bit.
  function automatic int hz_cnt_width(input int timeout);
    int w;
    w = (timeout <= 0) ? 1 : $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bus between the pipeline datapath (master) and the stall/flush
// sequencer (slave): ID/EX operand info, MEM handshake and the stage controls.
interface pipeline_hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  ex_redirect;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  stall_mem;
  logic                  flush_id;
  logic                  bubble_ex;
  logic                  bubble_wb;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_is_load, ex_redirect,
    output mem_req, mem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem,
    input  flush_id, bubble_ex, bubble_wb
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_is_load, ex_redirect,
    input  mem_req, mem_ready,
    output stall_if, stall_id, stall_ex, stall_mem,
    output flush_id, bubble_ex, bubble_wb
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics;
// it sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles, EX redirects,
// and a timed data-memory wait FSM. Perf counters are built only with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = HZ_REG_ADDR_W,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  pipeline_hazard_ctrl_if.slave hz,
  output logic                  mem_timeout,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      perf_lu,
  output logic [CNT_W-1:0]      perf_flush,
  output logic [CNT_W-1:0]      perf_memwait
);

  localparam int                WAIT_W    = hz_cnt_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  hz_state_e             state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  load_use;
  logic                  timeout_fire;
  logic                  mem_stall;

  logic                  stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
  logic                  flush_id_c, bubble_ex_c, bubble_wb_c;
  logic                  mem_timeout_c, err_sticky_c;

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;
  assign rd  = hz.ex_rd;

  assign load_use = hz.ex_is_load && (rd != '0) &&
                    ((hz.id_uses_rs1 && (rs1 == rd)) || (hz.id_uses_rs2 && (rs2 == rd)));

  // The abandon cycle itself is not a stall: the pipeline moves on with a dropped result.
  assign timeout_fire = (MEM_TIMEOUT != 0) && (state_q == MEM_WAIT) &&
                        !hz.mem_ready && (wait_q >= WAIT_LAST);

  assign mem_stall = ((state_q == RUN) && hz.mem_req && !hz.mem_ready) ||
                     ((state_q == MEM_WAIT) && !hz.mem_ready && !timeout_fire);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready || timeout_fire) begin
          state_d = RUN;
          wait_d  = '0;
          err_d   = err_q | timeout_fire;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Memory wait freezes EX, so redirect and load-use only act once it is released.
  always_comb begin
    stall_if_c    = 1'b0;
    stall_id_c    = 1'b0;
    stall_ex_c    = 1'b0;
    stall_mem_c   = 1'b0;
    flush_id_c    = 1'b0;
    bubble_ex_c   = 1'b0;
    bubble_wb_c   = 1'b0;
    mem_timeout_c = 1'b0;
    err_sticky_c  = 1'b0;
    if (resetn) begin
      if (mem_stall) begin
        stall_if_c  = 1'b1;
        stall_id_c  = 1'b1;
        stall_ex_c  = 1'b1;
        stall_mem_c = 1'b1;
        bubble_wb_c = 1'b1;
      end else begin
        if (hz.ex_redirect) begin
          flush_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end else if (load_use) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end
        if (timeout_fire) begin
          bubble_wb_c   = 1'b1;
          mem_timeout_c = 1'b1;
        end
      end
      err_sticky_c = err_q;
    end
  end

  assign hz.stall_if  = stall_if_c;
  assign hz.stall_id  = stall_id_c;
  assign hz.stall_ex  = stall_ex_c;
  assign hz.stall_mem = stall_mem_c;
  assign hz.flush_id  = flush_id_c;
  assign hz.bubble_ex = bubble_ex_c;
  assign hz.bubble_wb = bubble_wb_c;
  assign mem_timeout  = mem_timeout_c;
  assign err_sticky   = err_sticky_c;

`ifdef HAZARD_PERF_CNT_EN
  logic inc_lu, inc_flush, inc_memwait;

  assign inc_lu      = bubble_ex_c && !flush_id_c;
  assign inc_flush   = flush_id_c;
  assign inc_memwait = stall_mem_c;

  hazard_sat_counter #(.W(CNT_W)) u_perf_lu (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inc_lu),
    .count  (perf_lu)
  );

  hazard_sat_counter #(.W(CNT_W)) u_perf_flush (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inc_flush),
    .count  (perf_flush)
  );

  hazard_sat_counter #(.W(CNT_W)) u_perf_memwait (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inc_memwait),
    .count  (perf_memwait)
  );
`else
  assign perf_lu      = '0;
  assign perf_flush   = '0;
  assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// compared each cycle against an access-level model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_ADDR_W  = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic                  mem_timeout;
  logic                  err_sticky;
  logic [CNT_W-1:0]      perf_lu;
  logic [CNT_W-1:0]      perf_flush;
  logic [CNT_W-1:0]      perf_memwait;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W)) hz ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (REG_ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .hz           (hz),
    .mem_timeout  (mem_timeout),
    .err_sticky   (err_sticky),
    .perf_lu      (perf_lu),
    .perf_flush   (perf_flush),
    .perf_memwait (perf_memwait)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: an access is open until ready arrives or it has missed MEM_TIMEOUT times.
  bit inAccess  = 1'b0;
  int missCount = 0;
  bit sticky    = 1'b0;
  int nLu       = 0;
  int nFlush    = 0;
  int nWait     = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic verifyCycle(input string tag);
    bit         lu, active, memStall, toNow, redir;
    logic [8:0] expCtl, gotCtl;
    int         expLu, expFlush, expWait;
    #1;
    if (!resetn) begin
      inAccess  = 1'b0;
      missCount = 0;
      sticky    = 1'b0;
      nLu       = 0;
      nFlush    = 0;
      nWait     = 0;
    end
    lu = hz.ex_is_load && (hz.ex_rd != 0) &&
         ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
    redir    = hz.ex_redirect;
    active   = inAccess || hz.mem_req;
    memStall = 1'b0;
    toNow    = 1'b0;
    if (active && !hz.mem_ready) begin
      if (MEM_TIMEOUT != 0 && missCount + 1 == MEM_TIMEOUT) toNow = 1'b1;
      else memStall = 1'b1;
    end
    if (!resetn) expCtl = '0;
    else if (memStall) expCtl = {4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, sticky};
    else expCtl = {(lu && !redir), (lu && !redir), 2'b00, redir, (redir || lu), toNow, toNow, sticky};
    gotCtl = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem, hz.flush_id,
              hz.bubble_ex, hz.bubble_wb, mem_timeout, err_sticky};
`ifdef HAZARD_PERF_CNT_EN
    expLu = nLu; expFlush = nFlush; expWait = nWait;
`else
    expLu = 0; expFlush = 0; expWait = 0;
`endif
    checkOutput({tag, "/ctl"}, 32'(gotCtl), 32'(expCtl));
    checkOutput({tag, "/perf_lu"}, perf_lu, 32'(expLu));
    checkOutput({tag, "/perf_flush"}, perf_flush, 32'(expFlush));
    checkOutput({tag, "/perf_memwait"}, perf_memwait, 32'(expWait));
    if (resetn) begin
      if (active) begin
        if (hz.mem_ready || toNow) begin
          inAccess  = 1'b0;
          missCount = 0;
        end else begin
          inAccess  = 1'b1;
          missCount = missCount + 1;
        end
      end
      sticky = sticky | toNow;
      if (memStall) nWait++;
      else if (redir) nFlush++;
      else if (lu) nLu++;
    end
  endtask

  task automatic applyStimulus(input string tag,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit u1, input bit u2,
                               input logic [4:0] rd, input bit ld, input bit redir,
                               input bit req, input bit rdy);
    @(negedge clk);
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = u2;
    hz.ex_rd       = rd;
    hz.ex_is_load  = ld;
    hz.ex_redirect = redir;
    hz.mem_req     = req;
    hz.mem_ready   = rdy;
    verifyCycle(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic memCycle(input string tag, input bit req, input bit rdy);
    applyStimulus(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, req, rdy);
  endtask

  initial begin
    resetn = 1'b0;
    idle("reset");
    idle("reset2");
    resetn = 1'b1;
    idle("idle");

    applyStimulus("lu_rs2", 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("lu_after");
    applyStimulus("lu_rd0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("lu_unused", 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("lu_redir", 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) memCycle("memwait", 1'b1, 1'b0);
    memCycle("memdone", 1'b1, 1'b1);
    idle("memidle");

    applyStimulus("wait_lu", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    memCycle("wait_rel", 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) memCycle("timeout", 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) idle("sticky");

    for (int i = 0; i < 6; i++) memCycle("zerolat", 1'(i % 2), 1'b1);
    memCycle("rdy_noreq", 1'b0, 1'b1);

    memCycle("rst_run", 1'b1, 1'b0);
    memCycle("rst_mw1", 1'b1, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    verifyCycle("rst_mid");
    idle("rst_hold");
    resetn = 1'b1;
    idle("rst_rel");
    for (int i = 0; i < 4; i++) memCycle("post_rst_to", 1'b1, 1'b0);
    idle("post_rst_idle");

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
